// File: rtl/disp_sched.sv
// Display scheduler in front of the 8-digit hex scan driver.
// Shows the live word by default. Two message sources can post words into
// one-deep slots. Each posted word is shown for HOLD_CYCLES cycles, and
// the sources are picked round-robin when both are waiting.
//
// state | meaning
// IDLE  | live word tracked each cycle, waiting for a pending message
// SHOW  | message word held on the display while the hold timer counts down
module disp_sched #(
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] Live_data,
    input  logic        Msg1_vld,
    input  logic [31:0] Msg1_data,
    input  logic        Msg2_vld,
    input  logic [31:0] Msg2_data,
    output logic        Msg1_ack,
    output logic        Msg2_ack,
    output logic        Show_done,
    output logic [1:0]  Disp_src,
    output logic [31:0] Disp_data
);

    typedef enum logic {IDLE, SHOW} state_t;

    localparam logic [CNT_W-1:0] LP_HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_timer, w_timer_nxt;
    logic             r_pend1, r_pend2, w_pend1_nxt, w_pend2_nxt;
    logic [31:0]      r_slot1, r_slot2, w_slot1_nxt, w_slot2_nxt;
    logic [1:0]       r_last, w_last_nxt;
    logic [31:0]      r_disp_data, w_disp_data_nxt;
    logic [1:0]       r_disp_src, w_disp_src_nxt;
    logic             r_ack1, r_ack2, r_done;
    logic             w_ack1_nxt, w_ack2_nxt, w_done_nxt;
    logic             w_any, w_win2, w_load;

    // Register all scheduler state; reset discards pending slots too.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_pend1     <= 1'b0;
            r_pend2     <= 1'b0;
            r_slot1     <= '0;
            r_slot2     <= '0;
            r_last      <= 2'd2;
            r_disp_data <= '0;
            r_disp_src  <= 2'd0;
            r_ack1      <= 1'b0;
            r_ack2      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_pend1     <= w_pend1_nxt;
            r_pend2     <= w_pend2_nxt;
            r_slot1     <= w_slot1_nxt;
            r_slot2     <= w_slot2_nxt;
            r_last      <= w_last_nxt;
            r_disp_data <= w_disp_data_nxt;
            r_disp_src  <= w_disp_src_nxt;
            r_ack1      <= w_ack1_nxt;
            r_ack2      <= w_ack2_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Next-state logic: arbitration, hold timer, slot capture.
    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_pend1_nxt     = r_pend1;
        w_pend2_nxt     = r_pend2;
        w_slot1_nxt     = r_slot1;
        w_slot2_nxt     = r_slot2;
        w_last_nxt      = r_last;
        w_disp_data_nxt = r_disp_data;
        w_disp_src_nxt  = r_disp_src;
        w_ack1_nxt      = 1'b0;
        w_ack2_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_load          = 1'b0;

        // Only registered pend flags take part, so a strobe waits one cycle.
        w_any  = r_pend1 | r_pend2;
        w_win2 = r_pend2 & (~r_pend1 | (r_last == 2'd1));

        case (r_state)
            IDLE: begin
                w_disp_data_nxt = Live_data;
                w_disp_src_nxt  = 2'd0;
                w_load          = w_any;
            end
            SHOW: begin
                if (r_timer == '0) begin
                    w_done_nxt = 1'b1;
                    if (w_any) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt     = IDLE;
                        w_disp_data_nxt = Live_data;
                        w_disp_src_nxt  = 2'd0;
                    end
                end else begin
                    w_timer_nxt = r_timer - CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_load) begin
            w_state_nxt = SHOW;
            w_timer_nxt = LP_HOLD_M1;
            if (w_win2) begin
                w_disp_data_nxt = r_slot2;
                w_disp_src_nxt  = 2'd2;
                w_pend2_nxt     = 1'b0;
                w_ack2_nxt      = 1'b1;
                w_last_nxt      = 2'd2;
            end else begin
                w_disp_data_nxt = r_slot1;
                w_disp_src_nxt  = 2'd1;
                w_pend1_nxt     = 1'b0;
                w_ack1_nxt      = 1'b1;
                w_last_nxt      = 2'd1;
            end
        end

        // A strobe arriving as its slot is consumed stays pending.
        if (Msg1_vld) begin
            w_slot1_nxt = Msg1_data;
            w_pend1_nxt = 1'b1;
        end
        if (Msg2_vld) begin
            w_slot2_nxt = Msg2_data;
            w_pend2_nxt = 1'b1;
        end
    end

    assign Disp_data = r_disp_data;
    assign Disp_src  = r_disp_src;
    assign Msg1_ack  = r_ack1;
    assign Msg2_ack  = r_ack2;
    assign Show_done = r_done;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched with a 4-cycle hold.
module tb_disp_sched;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [31:0] Live_data;
    logic        Msg1_vld;
    logic [31:0] Msg1_data;
    logic        Msg2_vld;
    logic [31:0] Msg2_data;
    logic        Msg1_ack;
    logic        Msg2_ack;
    logic        Show_done;
    logic [1:0]  Disp_src;
    logic [31:0] Disp_data;

    int checks = 0;
    int errors = 0;

    disp_sched #(.HOLD_CYCLES(4), .CNT_W(3)) u_dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Live_data (Live_data),
        .Msg1_vld  (Msg1_vld),
        .Msg1_data (Msg1_data),
        .Msg2_vld  (Msg2_vld),
        .Msg2_data (Msg2_data),
        .Msg1_ack  (Msg1_ack),
        .Msg2_ack  (Msg2_ack),
        .Show_done (Show_done),
        .Disp_src  (Disp_src),
        .Disp_data (Disp_data)
    );

    always #5 Clk = ~Clk;

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Live_data = 32'h1234_5678;
        Msg1_vld = 1'b0; Msg1_data = '0;
        Msg2_vld = 1'b0; Msg2_data = '0;
        #2;
        checks++;
        if (Disp_data !== 32'h0 || Disp_src !== 2'd0 || Msg1_ack !== 1'b0 ||
            Msg2_ack !== 1'b0 || Show_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals data=%h src=%0d a1=%b a2=%b done=%b exp all zero",
                     Disp_data, Disp_src, Msg1_ack, Msg2_ack, Show_done);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge Clk);
            checks++;
            if (Disp_data !== 32'h1234_5678 || Disp_src !== 2'd0 ||
                Msg1_ack !== 1'b0 || Msg2_ack !== 1'b0 || Show_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_live j=%0d data=%h src=%0d a1=%b a2=%b done=%b exp 12345678/0/0/0/0",
                         j, Disp_data, Disp_src, Msg1_ack, Msg2_ack, Show_done);
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] exp_data;
        logic [1:0]  exp_src;
        Msg1_vld = 1'b1; Msg1_data = 32'hAAAA_0001;
        for (int j = 0; j <= 6; j++) begin
            @(negedge Clk);
            exp_src  = (j >= 1 && j <= 4) ? 2'd1 : 2'd0;
            exp_data = (j >= 1 && j <= 4) ? 32'hAAAA_0001 :
                       (j >= 5) ? 32'hDEAD_BEEF : 32'h1234_5678;
            checks++;
            if (Disp_data !== exp_data || Disp_src !== exp_src ||
                Msg1_ack !== (j == 1) || Msg2_ack !== 1'b0 || Show_done !== (j == 5)) begin
                errors++;
                $display("FAIL single j=%0d data=%h src=%0d a1=%b a2=%b done=%b exp %h/%0d/%b/0/%b",
                         j, Disp_data, Disp_src, Msg1_ack, Msg2_ack, Show_done,
                         exp_data, exp_src, (j == 1), (j == 5));
            end
            if (j == 0) Msg1_vld = 1'b0;
            if (j == 1) Live_data = 32'hDEAD_BEEF;
        end
    endtask

    task automatic test_tie();
        logic [31:0] exp_data;
        logic [1:0]  exp_src;
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            Msg1_vld = 1'b1; Msg1_data = 32'h1111_1111;
            Msg2_vld = 1'b1; Msg2_data = 32'h2222_2222;
            for (int j = 0; j <= 9; j++) begin
                @(negedge Clk);
                if (j == 0) begin Msg1_vld = 1'b0; Msg2_vld = 1'b0; end
                exp_src  = (j >= 1 && j <= 4) ? 2'd1 : (j >= 5 && j <= 8) ? 2'd2 : 2'd0;
                exp_data = (exp_src == 2'd1) ? 32'h1111_1111 :
                           (exp_src == 2'd2) ? 32'h2222_2222 : 32'hDEAD_BEEF;
                checks++;
                if (Disp_data !== exp_data || Disp_src !== exp_src ||
                    Msg1_ack !== (j == 1) || Msg2_ack !== (j == 5) ||
                    Show_done !== (j == 5 || j == 9)) begin
                    errors++;
                    $display("FAIL tie rep=%0d j=%0d data=%h src=%0d a1=%b a2=%b done=%b exp %h/%0d/%b/%b/%b",
                             rep, j, Disp_data, Disp_src, Msg1_ack, Msg2_ack, Show_done,
                             exp_data, exp_src, (j == 1), (j == 5), (j == 5 || j == 9));
                end
            end
        end
    endtask

    task automatic test_overwrite();
        logic [31:0] exp_data;
        logic [1:0]  exp_src;
        int          n_ack2;
        n_ack2 = 0;
        Live_data = 32'h5555_5555;
        Msg1_vld = 1'b1; Msg1_data = 32'hAAAA_0004;
        for (int j = 0; j <= 10; j++) begin
            @(negedge Clk);
            if (Msg2_ack === 1'b1) n_ack2++;
            exp_src  = (j >= 1 && j <= 4) ? 2'd1 : (j >= 5 && j <= 8) ? 2'd2 : 2'd0;
            exp_data = (exp_src == 2'd1) ? 32'hAAAA_0004 :
                       (exp_src == 2'd2) ? 32'h0000_0003 : 32'h5555_5555;
            checks++;
            if (Disp_data !== exp_data || Disp_src !== exp_src) begin
                errors++;
                $display("FAIL overwrite j=%0d data=%h src=%0d exp %h/%0d",
                         j, Disp_data, Disp_src, exp_data, exp_src);
            end
            case (j)
                0: Msg1_vld = 1'b0;
                1: begin Msg2_vld = 1'b1; Msg2_data = 32'h0000_0002; end
                2: Msg2_data = 32'h0000_0003;
                3: Msg2_vld = 1'b0;
                default: ;
            endcase
        end
        checks++;
        if (n_ack2 != 1) begin
            errors++;
            $display("FAIL overwrite_ack2 count=%0d exp 1", n_ack2);
        end
    endtask

    task automatic test_consume_collide();
        logic [31:0] exp_data;
        logic [1:0]  exp_src;
        Msg1_vld = 1'b1; Msg1_data = 32'hAAAA_0005;
        for (int j = 0; j <= 9; j++) begin
            @(negedge Clk);
            exp_src  = (j >= 1 && j <= 8) ? 2'd1 : 2'd0;
            exp_data = (j >= 1 && j <= 4) ? 32'hAAAA_0005 :
                       (j >= 5 && j <= 8) ? 32'hBBBB_0005 : 32'h5555_5555;
            checks++;
            if (Disp_data !== exp_data || Disp_src !== exp_src ||
                Msg1_ack !== (j == 1 || j == 5) || Msg2_ack !== 1'b0 ||
                Show_done !== (j == 5 || j == 9)) begin
                errors++;
                $display("FAIL collide j=%0d data=%h src=%0d a1=%b a2=%b done=%b exp %h/%0d/%b/0/%b",
                         j, Disp_data, Disp_src, Msg1_ack, Msg2_ack, Show_done,
                         exp_data, exp_src, (j == 1 || j == 5), (j == 5 || j == 9));
            end
            if (j == 0) Msg1_data = 32'hBBBB_0005;
            if (j == 1) Msg1_vld = 1'b0;
        end
    endtask

    task automatic test_reset_mid_show();
        Msg1_vld = 1'b1; Msg1_data = 32'hCCCC_0006;
        for (int j = 0; j <= 3; j++) begin
            @(negedge Clk);
            if (j == 0) Msg1_vld = 1'b0;
            if (j == 1) begin Msg2_vld = 1'b1; Msg2_data = 32'hDDDD_0006; end
            if (j == 2) Msg2_vld = 1'b0;
        end
        checks++;
        if (Disp_src !== 2'd1 || Disp_data !== 32'hCCCC_0006) begin
            errors++;
            $display("FAIL midshow_pre src=%0d data=%h exp 1/cccc0006", Disp_src, Disp_data);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (Disp_data !== 32'h0 || Disp_src !== 2'd0 || Msg1_ack !== 1'b0 ||
            Msg2_ack !== 1'b0 || Show_done !== 1'b0) begin
            errors++;
            $display("FAIL midshow_async data=%h src=%0d a1=%b a2=%b done=%b exp all zero",
                     Disp_data, Disp_src, Msg1_ack, Msg2_ack, Show_done);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge Clk);
            checks++;
            if (Disp_data !== 32'h5555_5555 || Disp_src !== 2'd0 ||
                Msg1_ack !== 1'b0 || Msg2_ack !== 1'b0 || Show_done !== 1'b0) begin
                errors++;
                $display("FAIL midshow_after j=%0d data=%h src=%0d a1=%b a2=%b done=%b exp 55555555/0/0/0/0",
                         j, Disp_data, Disp_src, Msg1_ack, Msg2_ack, Show_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_overwrite();
        test_consume_collide();
        test_reset_mid_show();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
